// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bus widths and the command-master FSM encoding.
package axi_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } cmd_state_e;

endpackage

// File: rtl/axi_cmd_watchdog.sv
// Transaction watchdog: counts busy cycles since command accept and flags expiry at TIMEOUT_CYCLES.
module axi_cmd_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  // expired is seen during the cycle whose closing edge would make the count reach the limit
  assign expired = run && (count_reg == LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (run && !expired) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator driven by a command stream, returning a response stream.
// Optional watchdog abort is built when AXI_CMD_MASTER_TIMEOUT_EN is defined.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_write,
  output logic        rsp_timeout,

  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,

  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,

  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,

  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,

  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  cmd_state_e state_reg, state_next;

  logic                  started_reg;
  logic                  awvalid_reg, wvalid_reg, arvalid_reg;
  logic [AXI_ADDR_W-1:0] awaddr_reg, araddr_reg;
  logic [AXI_DATA_W-1:0] wdata_reg;
  logic [AXI_STRB_W-1:0] wstrb_reg;
  logic [AXI_DATA_W-1:0] rsp_rdata_reg;
  logic [1:0]            rsp_resp_reg;
  logic                  rsp_write_reg;
  logic                  rsp_timeout_reg;

  logic cmd_ready_int;
  logic cmd_accept;
  logic aw_done, w_done;
  logic timeout;

  assign cmd_accept = cmd_valid && cmd_ready_int;

  // A channel counts as done once its valid has already dropped or it handshakes this cycle
  assign aw_done = !awvalid_reg || m_axi_awready;
  assign w_done  = !wvalid_reg  || m_axi_wready;

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
  logic busy;

  assign busy = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
                (state_reg == RD_REQ) || (state_reg == RD_RESP);

  axi_cmd_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (cmd_accept),
    .run     (busy),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_limit_unused
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_ready_int = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    case (state_reg)
      IDLE: begin
        // held low for the first cycle out of reset
        cmd_ready_int = started_reg;
        if (cmd_valid && started_reg) begin
          state_next = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (timeout) begin
          state_next = RSP;
        end else if (aw_done && w_done) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid || timeout) begin
          state_next = RSP;
        end
      end
      RD_REQ: begin
        if (timeout) begin
          state_next = RSP;
        end else if (m_axi_arready) begin
          state_next = RD_RESP;
        end
      end
      RD_RESP: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid || timeout) begin
          state_next = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      started_reg     <= 1'b0;
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      awaddr_reg      <= '0;
      araddr_reg      <= '0;
      wdata_reg       <= '0;
      wstrb_reg       <= '0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= AXI_RESP_OKAY;
      rsp_write_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      started_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (cmd_accept) begin
            rsp_write_reg   <= cmd_write;
            rsp_timeout_reg <= 1'b0;
            if (cmd_write) begin
              awaddr_reg  <= cmd_addr;
              wdata_reg   <= cmd_wdata;
              wstrb_reg   <= cmd_wstrb;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
            end else begin
              araddr_reg  <= cmd_addr;
              arvalid_reg <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (timeout) begin
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
          end else begin
            if (awvalid_reg && m_axi_awready) awvalid_reg <= 1'b0;
            if (wvalid_reg && m_axi_wready) wvalid_reg <= 1'b0;
          end
        end
        WR_RESP: begin
          // a real response arriving on the expiry cycle wins, since bready already accepted it
          if (m_axi_bvalid) begin
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= m_axi_bresp;
          end else if (timeout) begin
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
          end
        end
        RD_REQ: begin
          if (timeout) begin
            arvalid_reg     <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
          end else if (m_axi_arready) begin
            arvalid_reg <= 1'b0;
          end
        end
        RD_RESP: begin
          if (m_axi_rvalid) begin
            rsp_rdata_reg <= m_axi_rdata;
            rsp_resp_reg  <= m_axi_rresp;
          end else if (timeout) begin
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXI_RESP_SLVERR;
            rsp_timeout_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_int;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_resp      = rsp_resp_reg;
  assign rsp_write     = rsp_write_reg;
  assign rsp_timeout   = rsp_timeout_reg;

  assign m_axi_awaddr  = awaddr_reg;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = wstrb_reg;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arvalid = arvalid_reg;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Self-checking bench for axi_lite_cmd_master with a configurable-latency AXI4-Lite slave model.
// The watchdog sequence runs only when AXI_CMD_MASTER_TIMEOUT_EN is defined.
module tb_axi_lite_cmd_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axi_lite_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // slave model configuration, driven by the stimulus block
  int          s_aw_delay = 0, s_w_delay = 0, s_ar_delay = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'h0;

  int          aw_wait, w_wait, ar_wait;
  logic        aw_got, w_got;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  assign awready = awvalid && (aw_wait >= s_aw_delay);
  assign wready  = wvalid  && (w_wait  >= s_w_delay);
  assign arready = arvalid && (ar_wait >= s_ar_delay);

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
      cap_awaddr <= 32'h0; cap_wdata <= 32'h0; cap_wstrb <= 4'h0; cap_araddr <= 32'h0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      if (wvalid && !wready) w_wait <= w_wait + 1;
      if (arvalid && !arready) ar_wait <= ar_wait + 1;
      if (awvalid && awready) begin
        aw_wait <= 0; aw_got <= 1'b1; cap_awaddr <= awaddr;
      end
      if (wvalid && wready) begin
        w_wait <= 0; w_got <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb;
      end
      if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        bvalid <= 1'b1; bresp <= s_bresp; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_wait <= 0; rvalid <= 1'b1; rdata <= s_rdata; rresp <= s_rresp; cap_araddr <= araddr;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  int b_hs_cnt = 0, aw_hi_cnt = 0, w_hi_cnt = 0;
  always @(posedge aclk) begin
    if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
    if (awvalid) aw_hi_cnt <= aw_hi_cnt + 1;
    if (wvalid) w_hi_cnt <= w_hi_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Presents one command; returns once rsp_valid is seen (sampled 1 time unit after each edge)
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int acc_cyc, output int lat, output logic ok);
    int n;
    ok = 1'b0; lat = 0; acc_cyc = 0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    for (int i = 0; i < 100; i++) begin
      @(posedge aclk);
      #1;
      lat++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  sresp;
    logic [31:0] srdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int acc0, acc1, lat;
    logic ok;
    int viol;
    int b0, aw0, w0;
    logic [31:0] h_rdata;
    logic [1:0]  h_resp;

    vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 4'hF, 2'b00, 32'h0,         32'h0,         2'b00, 2};
    vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 2};
    vecs[2] = '{1'b1, 32'h0000_0004, 32'h0000_0041, 4'h1, 2'b10, 32'h0,         32'h0,         2'b10, 2};
    vecs[3] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 2'b11, 32'h1234_5678, 32'h1234_5678, 2'b11, 2};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 4'hA, 2'b01, 32'h0,         32'h0,         2'b01, 2};
    vecs[5] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 2'b10, 32'h0000_00FF, 32'h0000_00FF, 2'b10, 2};

    aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_valids", {28'h0, awvalid, wvalid, arvalid, bready | rready}, 32'h0);
    chk("rst_rsp_data", rsp_rdata | {30'h0, rsp_resp} | {31'h0, rsp_write | rsp_timeout}, 32'h0);
    chk("rst_axi_addr", awaddr | araddr | wdata | {28'h0, wstrb}, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("cmd_ready_before_first_edge", {31'h0, cmd_ready}, 32'h0);
    @(posedge aclk);
    #1;
    chk("cmd_ready_after_first_edge", {31'h0, cmd_ready}, 32'h1);

    for (int i = 0; i < 6; i++) begin
      s_bresp = vecs[i].sresp; s_rresp = vecs[i].sresp; s_rdata = vecs[i].srdata;
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, acc0, lat, ok);
      $display("TXN %0d wr=%0d addr=%08h rsp_rdata=%08h rsp_resp=%0d lat=%0d", i,
               vecs[i].wr, vecs[i].addr, rsp_rdata, rsp_resp, lat);
      chk($sformatf("v%0d_rsp_seen", i), {31'h0, ok}, 32'h1);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_resp", i), {30'h0, rsp_resp}, {30'h0, vecs[i].exp_resp});
      chk($sformatf("v%0d_write", i), {31'h0, rsp_write}, {31'h0, vecs[i].wr});
      chk($sformatf("v%0d_timeout", i), {31'h0, rsp_timeout}, 32'h0);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_awaddr", i), cap_awaddr, vecs[i].addr);
        chk($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].wdata);
        chk($sformatf("v%0d_wstrb", i), {28'h0, cap_wstrb}, {28'h0, vecs[i].strb});
      end else begin
        chk($sformatf("v%0d_araddr", i), cap_araddr, vecs[i].addr);
      end
    end

    // back-to-back throughput with a zero-wait slave
    s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = 32'h0000_0055;
    do_txn(1'b1, 32'h40, 32'h11, 4'hF, acc0, lat, ok);
    do_txn(1'b0, 32'h44, 32'h0, 4'h0, acc1, lat, ok);
    $display("TXN b2b accept_gap=%0d rsp_rdata=%08h", acc1 - acc0, rsp_rdata);
    chk("b2b_accept_gap", 32'(acc1 - acc0), 32'd4);
    chk("b2b_rdata", rsp_rdata, 32'h0000_0055);

    // awready delayed by 3, wready immediate
    s_aw_delay = 3;
    b0 = b_hs_cnt; aw0 = aw_hi_cnt; w0 = w_hi_cnt;
    do_txn(1'b1, 32'h80, 32'hCAFE_0001, 4'h3, acc0, lat, ok);
    repeat (2) @(posedge aclk);
    #1;
    $display("TXN aw_delay aw_hi=%0d w_hi=%0d b_hs=%0d lat=%0d", aw_hi_cnt - aw0, w_hi_cnt - w0,
             b_hs_cnt - b0, lat);
    chk("awdly_aw_cycles", 32'(aw_hi_cnt - aw0), 32'd4);
    chk("awdly_w_cycles", 32'(w_hi_cnt - w0), 32'd1);
    chk("awdly_b_handshakes", 32'(b_hs_cnt - b0), 32'd1);
    chk("awdly_latency", 32'(lat), 32'd5);
    s_aw_delay = 0;

    // response back-pressure: rsp_* must hold and no new command may start
    rsp_ready = 1'b0;
    s_rresp = 2'b01; s_rdata = 32'hCAFE_F00D;
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, acc0, lat, ok);
    h_rdata = rsp_rdata; h_resp = rsp_resp;
    chk("hold_rdata", h_rdata, 32'hCAFE_F00D);
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h7; cmd_wstrb = 4'hF;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk);
      #1;
      if (!rsp_valid || rsp_rdata !== h_rdata || rsp_resp !== h_resp || rsp_write !== 1'b0) viol++;
      if (cmd_ready || awvalid || wvalid || arvalid) viol++;
    end
    $display("TXN hold rsp_rdata=%08h violations=%0d", rsp_rdata, viol);
    chk("hold_violations", 32'(viol), 32'd0);
    @(negedge aclk);
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(posedge aclk);
    #1;
    chk("release_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("release_cmd_ready", {31'h0, cmd_ready}, 32'h1);

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    s_ar_delay = 1000;
    do_txn(1'b0, 32'hC, 32'h0, 4'h0, acc0, lat, ok);
    $display("TXN timeout lat=%0d rsp_resp=%0d rsp_timeout=%0d", lat, rsp_resp, rsp_timeout);
    chk("to_seen", {31'h0, ok}, 32'h1);
    chk("to_latency", 32'(lat), 32'd16);
    chk("to_resp", {30'h0, rsp_resp}, 32'h2);
    chk("to_flag", {31'h0, rsp_timeout}, 32'h1);
    chk("to_rdata", rsp_rdata, 32'h0);
    chk("to_arvalid", {31'h0, arvalid}, 32'h0);
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    s_ar_delay = 0;
    @(posedge aclk);
`endif

    // asynchronous reset while a write is in flight
    s_aw_delay = 20;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h90; cmd_wdata = 32'h99; cmd_wstrb = 4'hF;
    while (!cmd_ready) @(negedge aclk);
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    chk("mid_awvalid_set", {31'h0, awvalid}, 32'h1);
    #2;
    aresetn = 1'b0;
    #1;
    $display("TXN mid_reset awvalid=%0d wvalid=%0d", awvalid, wvalid);
    chk("mid_reset_valids", {30'h0, awvalid, wvalid}, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    s_aw_delay = 0;
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk);
      #1;
      if (rsp_valid || awvalid || wvalid) viol++;
    end
    chk("post_reset_no_stale", 32'(viol), 32'd0);
    chk("post_reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
